prng_word_gen: RTL and testbench

Word-level pseudo-random source for the PRNG design. It loads a seed, steps a Galois LFSR one bit per cycle, and packs the output bits MSB-first into OUT_WIDTH-bit words. Each word is offered on a valid/ready port to the downstream consumer: the display and readout path, or the statistics counter. It is the generation stage feeding the register, counter and comparator primitives in the shared library.

---
 rtl/prng_pkg.sv | 14 +
 rtl/prng_lfsr_reg.sv | 42 ++++
 rtl/prng_word_gen.sv | 149 ++++++++++++++
 tb/tb_prng_word_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and default constants for the word-level PRNG.
// Holds the FSM state encoding plus the default feedback mask and seed.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [15:0] PRNG_TAPS         = 16'hB400;
  localparam logic [15:0] PRNG_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/prng_lfsr_reg.sv
// Galois LFSR register: loads a value, or shifts right one bit per step,
// XORing TAPS back in when the bit leaving position 0 is a one.
module prng_lfsr_reg
  import prng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(PRNG_TAPS),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(PRNG_DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic             out_bit,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_value;
    end else if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_bit = lfsr_q[0];
  assign state   = lfsr_q;

endmodule

// File: rtl/prng_word_gen.sv
// Seeded Galois-LFSR word generator with a valid/ready output port.
// Optional PRNG_ZERO_GUARD_EN: an all-zero seed loads DEFAULT_SEED instead.
module prng_word_gen
  import prng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(PRNG_TAPS),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(PRNG_DEFAULT_SEED),
  parameter int               OUT_WIDTH    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 seed_valid,
  input  logic [WIDTH-1:0]     seed,
  output logic                 seed_ready,
  input  logic                 start,
  input  logic                 stop,
  output logic                 rand_valid,
  input  logic                 rand_ready,
  output logic [OUT_WIDTH-1:0] rand_data,
  output logic                 busy,
  output logic [15:0]          word_count,
  output logic [WIDTH-1:0]     lfsr_state,
  output logic [1:0]           state_dbg
);

  localparam int               CNT_W    = (OUT_WIDTH > 2) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_WIDTH - 1);

  // Output port: rand_data is held stable while rand_valid is high; a word
  // transfers on any rising clock edge where rand_valid and rand_ready are both high.

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [OUT_WIDTH-2:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] rand_data_q, rand_data_d;
  logic                 rand_valid_q, rand_valid_d;
  logic [15:0]          word_count_q, word_count_d;
  logic                 stop_pending_q, stop_pending_d;

  logic                 lfsr_load;
  logic                 lfsr_step;
  logic                 out_bit;
  logic [WIDTH-1:0]     load_value;
  logic [OUT_WIDTH-1:0] shifted;

`ifdef PRNG_ZERO_GUARD_EN
  assign load_value = (seed == '0) ? DEFAULT_SEED : seed;
`else
  assign load_value = seed;
`endif

  prng_lfsr_reg #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (load_value),
    .step       (lfsr_step),
    .out_bit    (out_bit),
    .state      (lfsr_state)
  );

  // Top bit of the shifted accumulator is the oldest (first) bit of the word.
  assign shifted = {acc_q, out_bit};

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    acc_d          = acc_q;
    rand_data_d    = rand_data_q;
    rand_valid_d   = rand_valid_q;
    word_count_d   = word_count_q;
    stop_pending_d = stop_pending_q;
    lfsr_load      = 1'b0;
    lfsr_step      = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pending_d = 1'b0;
        if (seed_valid) begin
          lfsr_load    = 1'b1;
          word_count_d = '0;
        end
        if (start) begin
          state_d   = GEN;
          bit_cnt_d = '0;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        acc_d     = shifted[OUT_WIDTH-2:0];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (stop) stop_pending_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          rand_data_d  = shifted;
          rand_valid_d = 1'b1;
          bit_cnt_d    = '0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (stop) stop_pending_d = 1'b1;
        if (rand_valid_q && rand_ready) begin
          rand_valid_d = 1'b0;
          word_count_d = word_count_q + 16'd1;
          // A stop in the handshake cycle still ends generation here.
          if (stop_pending_q || stop) begin
            state_d        = IDLE;
            stop_pending_d = 1'b0;
          end else begin
            state_d = GEN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      acc_q          <= '0;
      rand_data_q    <= '0;
      rand_valid_q   <= 1'b0;
      word_count_q   <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      acc_q          <= acc_d;
      rand_data_q    <= rand_data_d;
      rand_valid_q   <= rand_valid_d;
      word_count_q   <= word_count_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  assign seed_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rand_valid = rand_valid_q;
  assign rand_data  = rand_data_q;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_prng_word_gen.sv
// Directed bench for prng_word_gen with a reference LFSR model feeding an
// expected-word queue that is drained on each output handshake.
module tb_prng_word_gen;

  localparam int W  = 16;
  localparam int OW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          seed_valid;
  logic [W-1:0]  seed;
  logic          seed_ready;
  logic          start;
  logic          stop;
  logic          rand_valid;
  logic          rand_ready;
  logic [OW-1:0] rand_data;
  logic          busy;
  logic [15:0]   word_count;
  logic [W-1:0]  lfsr_state;
  logic [1:0]    state_dbg;

  // clock / reset
  always #5 clock = ~clock;

  prng_word_gen dut (
    .clock      (clock),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .start      (start),
    .stop       (stop),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .rand_data  (rand_data),
    .busy       (busy),
    .word_count (word_count),
    .lfsr_state (lfsr_state),
    .state_dbg  (state_dbg)
  );

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  m_lfsr;
  logic [OW-1:0] last_word = '0;
  int            exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: run OUT_WIDTH Galois steps and queue the packed word.
  task automatic gen_expected();
    logic [OW-1:0] w;
    logic          b;
    w = '0;
    for (int i = 0; i < OW; i++) begin
      b      = m_lfsr[0];
      m_lfsr = (m_lfsr >> 1) ^ (b ? 16'hB400 : 16'h0000);
      w      = {w[OW-2:0], b};
    end
    exp_q.push_back(w);
  endtask

  task automatic seed_model(input logic [W-1:0] s);
`ifdef PRNG_ZERO_GUARD_EN
    m_lfsr = (s == '0) ? 16'hACE1 : s;
`else
    m_lfsr = s;
`endif
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (rand_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, rand_valid, 1);
    if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic take_word(input string tag);
    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      last_word = exp_q.pop_front();
      check({tag, "_data"}, rand_data, last_word);
    end
  endtask

  // Compare the offered word, then let the handshake edge pass (rand_ready=1).
  task automatic accept(input string tag);
    take_word(tag);
    tick();
    exp_count++;
    check({tag, "_count"}, word_count, exp_count);
    check({tag, "_valid_drop"}, rand_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    seed_valid = 1'b0;
    seed       = '0;
    start      = 1'b0;
    stop       = 1'b0;
    rand_ready = 1'b0;
    #1;
    check("rst_valid", rand_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_seed_ready", seed_ready, 1);
    check("rst_count", word_count, 0);
    check("rst_data", rand_data, 0);
    check("rst_lfsr", lfsr_state, 16'hACE1);
    check("rst_state", state_dbg, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // First word from the reset seed, consumer stalled for 20 cycles.
    m_lfsr = 16'hACE1;
    gen_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_seed_ready", seed_ready, 0);
    wait_valid(8, "w0");
    take_word("w0");
    check("w0_lfsr", lfsr_state, m_lfsr);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", rand_valid, 1);
      check("hold_data", rand_data, last_word);
      check("hold_lfsr", lfsr_state, m_lfsr);
      check("hold_count", word_count, 0);
    end
    rand_ready = 1'b1;
    tick();
    exp_count = 1;
    check("w0_count", word_count, exp_count);
    check("w0_valid_drop", rand_valid, 0);
    gen_expected();

    // Back-to-back words at full throughput.
    for (int i = 0; i < 3; i++) begin
      wait_valid(8, "stream");
      accept("stream");
      gen_expected();
    end

    // stop mid-GEN: current word finishes, then IDLE.
    tick();
    tick();
    pulse_stop();
    wait_valid(-1, "stopw");
    accept("stopw");
    check("stop_busy", busy, 0);
    check("stop_seed_ready", seed_ready, 1);
    check("stop_state", state_dbg, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", rand_valid, 0);
      check("idle_data", rand_data, last_word);
    end

    // Seed and start together; seed offers while busy are ignored.
    rand_ready = 1'b0;
    seed_valid = 1'b1;
    seed       = 16'hACE1;
    start      = 1'b1;
    seed_model(16'hACE1);
    gen_expected();
    tick();
    start     = 1'b0;
    exp_count = 0;
    check("seed_count_clr", word_count, 0);
    check("seed_busy", busy, 1);
    seed = 16'h1234;
    check("busy_seed_ready", seed_ready, 0);
    wait_valid(8, "sw");
    tick();
    tick();
    check("hold_seed_ignored", lfsr_state, m_lfsr);
    seed_valid = 1'b0;
    take_word("sw");
    stop       = 1'b1;
    rand_ready = 1'b1;
    tick();
    stop = 1'b0;
    exp_count++;
    check("sw_count", word_count, exp_count);
    check("sw_stop_busy", busy, 0);
    check("sw_valid_drop", rand_valid, 0);

    // Zero seed.
    seed_valid = 1'b1;
    seed       = 16'h0000;
    start      = 1'b1;
    seed_model(16'h0000);
    gen_expected();
    tick();
    seed_valid = 1'b0;
    start      = 1'b0;
    exp_count  = 0;
    check("zero_count_clr", word_count, 0);
    for (int i = 0; i < 2; i++) begin
      wait_valid(8, "zero");
      accept("zero");
      gen_expected();
    end
    tick();
    tick();
    pulse_stop();
    wait_valid(-1, "zerolast");
    accept("zerolast");
    check("zero_stop_busy", busy, 0);

    // Asynchronous reset in the middle of GEN.
    rand_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", rand_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_lfsr", lfsr_state, 16'hACE1);
    check("arst_count", word_count, 0);
    check("arst_data", rand_data, 0);
    check("arst_state", state_dbg, 0);
    exp_q.delete();
    exp_count = 0;
    tick();
    reset = 1'b0;
    tick();

    // Generation restarts cleanly from the default seed.
    m_lfsr = 16'hACE1;
    gen_expected();
    rand_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(8, "post_rst");
    accept("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
